// File: rtl/dvp_rgb565_tx.sv
// dvp_rgb565_tx
//   Sensor emulator: turns RGB565 pixels pulled over valid/ready into an
//   8-bit DVP stream (high byte first). Frame timing comes entirely from
//   internal line/column counters. The pixel source only supplies data.
//
// Ports
//   i_pclk        byte clock; every output is registered on its rising edge
//   rst_n         synchronous, active-low reset
//   i_en          frame enable, sampled only while idle
//   i_pix_data    RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//   i_pix_valid   i_pix_data is valid
//   o_pix_ready   a pixel is taken at this edge if i_pix_valid is high
//   o_vsync       frame sync, high during the VSYNC lines
//   o_href        line valid, high during active bytes
//   o_pdata       DVP byte
//   o_underrun    one-cycle pulse in a pixel slot that found no valid pixel
//   o_frame_done  one-cycle pulse after the last front-porch clock
//   o_busy        high whenever a frame is in progress
module dvp_rgb565_tx #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned H_BLANK   = 160,
    parameter int unsigned VS_LINES  = 3,
    parameter int unsigned VBP_LINES = 17,
    parameter int unsigned VFP_LINES = 10
) (
    input  logic        i_pclk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [15:0] i_pix_data,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_pdata,
    output logic        o_underrun,
    output logic        o_frame_done,
    output logic        o_busy
);

    localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned HW       = $clog2(LINE_LEN);
    localparam int unsigned MAX_A    = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
    localparam int unsigned MAX_B    = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
    localparam int unsigned MAX_LN   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned LNW      = (MAX_LN > 1) ? $clog2(MAX_LN) : 1;

    localparam logic [HW-1:0]  H_LAST   = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0]  TWO_H    = HW'(2 * H_ACTIVE);
    localparam logic [LNW-1:0] VS_LAST  = LNW'((VS_LINES  > 0) ? VS_LINES  - 1 : 0);
    localparam logic [LNW-1:0] VBP_LAST = LNW'((VBP_LINES > 0) ? VBP_LINES - 1 : 0);
    localparam logic [LNW-1:0] ACT_LAST = LNW'((V_ACTIVE  > 0) ? V_ACTIVE  - 1 : 0);
    localparam logic [LNW-1:0] VFP_LAST = LNW'((VFP_LINES > 0) ? VFP_LINES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBP    = 3'd2,
        ACTIVE = 3'd3,
        VFP    = 3'd4
    } state_t;

    // Position in the frame timeline: state, byte column, line within state.
    typedef struct packed {
        state_t         st;
        logic [HW-1:0]  h;
        logic [LNW-1:0] line;
    } pos_t;

    // Zero-line states are passed through without spending a clock.
    function automatic state_t skip_from(state_t s);
        state_t r;
        r = s;
        if (r == VSYNC  && VS_LINES  == 0) r = VBP;
        if (r == VBP    && VBP_LINES == 0) r = ACTIVE;
        if (r == ACTIVE && V_ACTIVE  == 0) r = VFP;
        if (r == VFP    && VFP_LINES == 0) r = IDLE;
        return r;
    endfunction

    function automatic state_t after(state_t s);
        state_t r;
        case (s)
            VSYNC:   r = skip_from(VBP);
            VBP:     r = skip_from(ACTIVE);
            ACTIVE:  r = skip_from(VFP);
            default: r = IDLE;
        endcase
        return r;
    endfunction

    function automatic logic [LNW-1:0] last_line(state_t s);
        logic [LNW-1:0] r;
        case (s)
            VSYNC:   r = VS_LAST;
            VBP:     r = VBP_LAST;
            ACTIVE:  r = ACT_LAST;
            VFP:     r = VFP_LAST;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic pos_t step(pos_t p, logic en);
        pos_t q;
        q = p;
        if (p.st == IDLE) begin
            q.h    = '0;
            q.line = '0;
            if (en) q.st = skip_from(VSYNC);
        end else if (p.h == H_LAST) begin
            q.h = '0;
            if (p.line == last_line(p.st)) begin
                q.line = '0;
                q.st   = after(p.st);
            end else begin
                q.line = p.line + 1'b1;
            end
        end else begin
            q.h = p.h + 1'b1;
        end
        return q;
    endfunction

    // True when the clock following position p is an even (high-byte) slot.
    // Never true from IDLE: i_en is unknown a cycle ahead, so with no VSYNC
    // and no VBP lines the first slot of a frame is reported as an underrun.
    function automatic logic next_is_even_slot(pos_t p);
        logic r;
        if (p.h == H_LAST) begin
            if (p.line == last_line(p.st)) r = (after(p.st) == ACTIVE);
            else                           r = (p.st == ACTIVE);
        end else begin
            r = (p.st == ACTIVE) && p.h[0] && (p.h < TWO_H - 1'b1);
        end
        return r;
    endfunction

    state_t         state;
    logic [HW-1:0]  h_cnt;
    logic [LNW-1:0] line_cnt;
    logic [7:0]     lo_hold;

    pos_t        cur;
    pos_t        nxt;
    logic        take;
    logic [15:0] pix;
    logic        vsync_d;
    logic        href_d;
    logic        ready_d;
    logic        underrun_d;
    logic        done_d;
    logic        busy_d;
    logic [7:0]  pdata_d;

    // Outputs are registered, so everything is decoded from the position of
    // the coming clock (nxt); ready looks one further clock ahead.
    always_comb begin
        cur        = '{st: state, h: h_cnt, line: line_cnt};
        nxt        = step(cur, i_en);
        take       = o_pix_ready && i_pix_valid;
        pix        = take ? i_pix_data : '0;
        vsync_d    = (nxt.st == VSYNC);
        href_d     = (nxt.st == ACTIVE) && (nxt.h < TWO_H);
        ready_d    = next_is_even_slot(nxt);
        underrun_d = href_d && !nxt.h[0] && !take;
        done_d     = (state != IDLE) && (nxt.st == IDLE);
        busy_d     = (nxt.st != IDLE);
        pdata_d    = '0;
        if (href_d) pdata_d = nxt.h[0] ? lo_hold : pix[15:8];
    end

    always_ff @(posedge i_pclk) begin
        if (!rst_n) begin
            state        <= IDLE;
            h_cnt        <= '0;
            line_cnt     <= '0;
            lo_hold      <= '0;
            o_pix_ready  <= 1'b0;
            o_vsync      <= 1'b0;
            o_href       <= 1'b0;
            o_pdata      <= '0;
            o_underrun   <= 1'b0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= nxt.st;
            h_cnt        <= nxt.h;
            line_cnt     <= nxt.line;
            o_pix_ready  <= ready_d;
            o_vsync      <= vsync_d;
            o_href       <= href_d;
            o_pdata      <= pdata_d;
            o_underrun   <= underrun_d;
            o_frame_done <= done_d;
            o_busy       <= busy_d;
            if (href_d && !nxt.h[0]) lo_hold <= pix[7:0];
        end
    end

endmodule

// File: tb/tb_dvp_rgb565_tx.sv
// Testbench for dvp_rgb565_tx with a small frame (L=12, 60-clock frame).
// Expected outputs per clock come from frame arithmetic on the clock index.
module tb_dvp_rgb565_tx;

    localparam int unsigned HA    = 4;
    localparam int unsigned VA    = 2;
    localparam int unsigned HB    = 4;
    localparam int unsigned VSL   = 1;
    localparam int unsigned VBPL  = 1;
    localparam int unsigned VFPL  = 1;
    localparam int unsigned L     = 2 * HA + HB;
    localparam int unsigned ACT0  = (VSL + VBPL) * L;
    localparam int unsigned ACT1  = ACT0 + VA * L;
    localparam int unsigned FRAME = (VSL + VBPL + VA + VFPL) * L;
    localparam int unsigned NPIX  = HA * VA;

    logic        i_pclk;
    logic        rst_n;
    logic        i_en;
    logic [15:0] i_pix_data;
    logic        i_pix_valid;
    logic        o_pix_ready;
    logic        o_vsync;
    logic        o_href;
    logic [7:0]  o_pdata;
    logic        o_underrun;
    logic        o_frame_done;
    logic        o_busy;

    dvp_rgb565_tx #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .VS_LINES (VSL),
        .VBP_LINES(VBPL),
        .VFP_LINES(VFPL)
    ) dut (
        .i_pclk      (i_pclk),
        .rst_n       (rst_n),
        .i_en        (i_en),
        .i_pix_data  (i_pix_data),
        .i_pix_valid (i_pix_valid),
        .o_pix_ready (o_pix_ready),
        .o_vsync     (o_vsync),
        .o_href      (o_href),
        .o_pdata     (o_pdata),
        .o_underrun  (o_underrun),
        .o_frame_done(o_frame_done),
        .o_busy      (o_busy)
    );

    initial i_pclk = 1'b0;
    always #5 i_pclk = ~i_pclk;

    logic [13:0] dut_vec;
    assign dut_vec = {o_vsync, o_href, o_pdata, o_pix_ready, o_underrun, o_frame_done, o_busy};

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] plan_data  [NPIX];
    logic        plan_valid [NPIX];
    int unsigned feed_idx;
    int unsigned und_seen;

    // Partner 8-to-16 receiver: pairs bytes within each href run.
    logic        rx_arm  = 1'b0;
    logic        rx_have = 1'b0;
    logic [7:0]  rx_hi   = '0;
    logic [15:0] rx_q [$];

    always @(negedge i_pclk) begin
        if (o_href && rx_arm) begin
            if (rx_have) begin
                rx_q.push_back({rx_hi, o_pdata});
                rx_have <= 1'b0;
            end else begin
                rx_hi   <= o_pdata;
                rx_have <= 1'b1;
            end
        end else begin
            rx_have <= 1'b0;
        end
    end

    task automatic check(input string nm, input int unsigned idx,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s idx=%0d got=%h expected=%h", nm, idx, got, exp);
        end
    endtask

    // Expected {vsync, href, pdata, ready, underrun, done, busy} for clock k
    // of a frame (k=0 is the first vsync clock, k=FRAME the idle clock).
    function automatic logic [13:0] model(input int unsigned k);
        logic        vs, href, rdy, und, done, busy;
        logic [7:0]  pd;
        logic [15:0] w;
        int unsigned col, p, kn;
        vs   = (k < VSL * L);
        href = 1'b0;
        pd   = '0;
        und  = 1'b0;
        col  = k % L;
        if (k >= ACT0 && k < ACT1 && col < 2 * HA) begin
            href = 1'b1;
            p    = ((k - ACT0) / L) * HA + col / 2;
            w    = plan_valid[p] ? plan_data[p] : 16'h0000;
            pd   = (col % 2 == 0) ? w[15:8] : w[7:0];
            und  = (col % 2 == 0) && !plan_valid[p];
        end
        kn   = k + 1;
        rdy  = (kn >= ACT0) && (kn < ACT1) && ((kn % L) < 2 * HA) && ((kn % L) % 2 == 0);
        done = (k == FRAME);
        busy = (k < FRAME);
        return {vs, href, pd, rdy, und, done, busy};
    endfunction

    task automatic fill_plan(input logic [NPIX-1:0] mask, input bit rnd);
        for (int unsigned i = 0; i < NPIX; i++) begin
            logic [7:0] hi;
            logic [7:0] lo;
            hi = 8'hA1 + 8'(i * 34);
            lo = 8'hB2 + 8'(i * 34);
            plan_valid[i] = mask[i];
            plan_data[i]  = rnd ? 16'($urandom) : {hi, lo};
        end
    endtask

    // Source: presents the next planned pixel only when ready is up, junk
    // otherwise; i_en is randomised while it must be ignored.
    task automatic drive(input int unsigned k, input bit en_at_end);
        if (o_pix_ready && feed_idx < NPIX) begin
            i_pix_valid = plan_valid[feed_idx];
            i_pix_data  = plan_valid[feed_idx] ? plan_data[feed_idx] : 16'($urandom);
            feed_idx++;
        end else begin
            i_pix_valid = 1'($urandom);
            i_pix_data  = 16'($urandom);
        end
        i_en = (k >= FRAME) ? en_at_end : 1'($urandom);
    endtask

    // Entered at the negedge where clock k=0 of a frame is visible.
    task automatic run_frame(input int unsigned last_k, input bit en_at_end);
        feed_idx = 0;
        for (int unsigned k = 0; k <= last_k; k++) begin
            if (k > 0) @(negedge i_pclk);
            if (o_underrun) und_seen++;
            check("frame", k, 32'(dut_vec), 32'(model(k)));
            drive(k, en_at_end);
        end
    endtask

    typedef struct {
        string           name;
        logic [NPIX-1:0] mask;
        bit              rand_data;
        int unsigned     frames;
        bit              hold_en;
        int unsigned     exp_und;
    } scen_t;

    scen_t tbl [5];

    initial begin
        tbl[0] = '{name: "seq_pixels", mask: 8'hFF, rand_data: 1'b0, frames: 1, hold_en: 1'b0, exp_und: 0};
        tbl[1] = '{name: "drop_slot1", mask: 8'hFD, rand_data: 1'b0, frames: 1, hold_en: 1'b0, exp_und: 1};
        tbl[2] = '{name: "rand_b2b",   mask: 8'hFF, rand_data: 1'b1, frames: 3, hold_en: 1'b1, exp_und: 0};
        tbl[3] = '{name: "rand_holes", mask: 8'h5A, rand_data: 1'b1, frames: 2, hold_en: 1'b1, exp_und: 8};
        tbl[4] = '{name: "all_under",  mask: 8'h00, rand_data: 1'b1, frames: 1, hold_en: 1'b0, exp_und: 8};

        rst_n       = 1'b0;
        i_en        = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data  = '0;
        repeat (3) @(negedge i_pclk);
        check("reset", 0, 32'(dut_vec), 32'h0);
        rst_n = 1'b1;

        // Idle with junk on the pixel inputs: nothing may move.
        for (int i = 0; i < 20; i++) begin
            @(negedge i_pclk);
            check("idle", i, 32'(dut_vec), 32'h0);
            i_pix_valid = 1'($urandom);
            i_pix_data  = 16'($urandom);
        end

        for (int s = 0; s < 5; s++) begin
            und_seen = 0;
            @(negedge i_pclk);
            check("pre_idle", s, 32'(dut_vec), 32'h0);
            i_en = 1'b1;
            @(negedge i_pclk);
            for (int unsigned f = 0; f < tbl[s].frames; f++) begin
                if (f > 0) @(negedge i_pclk);
                fill_plan(tbl[s].mask, tbl[s].rand_data);
                run_frame(FRAME, (f + 1 < tbl[s].frames) ? tbl[s].hold_en : 1'b0);
            end
            check(tbl[s].name, s, 32'(und_seen), 32'(tbl[s].exp_und));
        end

        // Reset in the middle of the first active line, then a fresh frame.
        @(negedge i_pclk);
        i_en = 1'b1;
        @(negedge i_pclk);
        fill_plan(8'hFF, 1'b1);
        run_frame(ACT0 + 2, 1'b0);
        rst_n = 1'b0;
        i_en  = 1'b0;
        @(negedge i_pclk);
        check("rst_mid", 0, 32'(dut_vec), 32'h0);
        rst_n = 1'b1;
        i_en  = 1'b1;
        @(negedge i_pclk);
        fill_plan(8'hFF, 1'b1);
        run_frame(FRAME, 1'b0);

        // Loopback into the receiver.
        @(negedge i_pclk);
        i_en = 1'b1;
        rx_q.delete();
        rx_arm = 1'b1;
        @(negedge i_pclk);
        fill_plan(8'hFF, 1'b1);
        run_frame(FRAME, 1'b0);
        rx_arm = 1'b0;
        check("rx_count", 0, 32'(rx_q.size()), 32'(NPIX));
        for (int unsigned i = 0; i < NPIX && i < rx_q.size(); i++)
            check("rx_word", i, 32'(rx_q[i]), 32'(plan_data[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
